// File: rtl/rc4_pkg.sv
// rc4_pkg: shared state encoding, plaintext character bounds and default message length.
package rc4_pkg;
  typedef enum logic [3:0] {
    IDLE, INIT, INC_I, RD_SI, W_SI, CALC_J, RD_SJ, W_SJ,
    CAP_SJ, WR_SI, WR_SJ, RD_F, W_F, XOR_WR, NEXT, DONE
  } state_t;
  localparam logic [7:0] CHAR_A = 8'h61;
  localparam logic [7:0] CHAR_Z = 8'h7A;
  localparam logic [7:0] CHAR_SP = 8'h20;
  localparam int MSG_LEN_DEF = 32;
endpackage

// File: rtl/flopr_en.sv
// flopr_en: enabled register with asynchronous active-low clear.
module flopr_en #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/rc4_char_valid.sv
// rc4_char_valid: flags bytes that are lowercase letters or space.
module rc4_char_valid import rc4_pkg::*; (
  input  logic [7:0] ch,
  output logic       valid
);
  assign valid = (ch >= CHAR_A && ch <= CHAR_Z) || ch == CHAR_SP;
endmodule

// File: rtl/rc4_decrypt.sv
// rc4_decrypt: RC4 PRGA over an external S RAM, XOR-decrypting the encrypted ROM into plaintext RAM.
module rc4_decrypt import rc4_pkg::*; #(
  parameter int MSG_LEN = MSG_LEN_DEF,
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 2,
  parameter int CHECK_TEXT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              ack,
  output logic [7:0]        s_address,
  output logic [7:0]        s_data,
  output logic              s_write_en,
  input  logic [7:0]        s_read_data,
  output logic [ADDR_W-1:0] enc_address,
  input  logic [7:0]        enc_read_data,
  output logic [ADDR_W-1:0] dec_address,
  output logic [7:0]        dec_data,
  output logic              dec_write_en,
  output logic              finished,
  output logic              key_valid
);
  state_t state, nxt;
  logic [7:0] i, j, si, sj, cnt, p, sum;
  logic [ADDR_W-1:0] k;
  logic ok, pass, last, wt, cnt_done, kv;
  assign p = s_read_data ^ enc_read_data;
  assign sum = si + sj;
  assign pass = ok || CHECK_TEXT == 0;
  assign last = k == ADDR_W'(MSG_LEN - 1);
  assign wt = state inside {W_SI, W_SJ, W_F};
  assign cnt_done = cnt == 8'(RD_LAT - 1);
  rc4_char_valid u_cv (.ch(p), .valid(ok));
  flopr_en #(8) u_i (.clk, .reset_n, .en(state == INIT || state == INC_I),
    .d(state == INIT ? 8'h00 : i + 8'h01), .q(i));
  flopr_en #(8) u_j (.clk, .reset_n, .en(state == INIT || state == CALC_J),
    .d(state == INIT ? 8'h00 : j + s_read_data), .q(j));
  flopr_en #(8) u_si (.clk, .reset_n, .en(state == CALC_J), .d(s_read_data), .q(si));
  flopr_en #(8) u_sj (.clk, .reset_n, .en(state == CAP_SJ), .d(s_read_data), .q(sj));
  flopr_en #(ADDR_W) u_k (.clk, .reset_n, .en(state == INIT || (state == NEXT && !last)),
    .d(state == INIT ? '0 : k + 1'b1), .q(k));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      kv <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= (wt && !cnt_done) ? cnt + 8'h01 : 8'h00;
      kv <= state == INIT ? 1'b1 : ((state == XOR_WR && !pass) || (state == DONE && ack)) ? 1'b0 : kv;
    end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:   nxt = start ? INIT : IDLE;
      INIT:   nxt = INC_I;
      INC_I:  nxt = RD_SI;
      RD_SI:  nxt = RD_LAT == 0 ? CALC_J : W_SI;
      W_SI:   nxt = cnt_done ? CALC_J : W_SI;
      CALC_J: nxt = RD_SJ;
      RD_SJ:  nxt = RD_LAT == 0 ? CAP_SJ : W_SJ;
      W_SJ:   nxt = cnt_done ? CAP_SJ : W_SJ;
      CAP_SJ: nxt = WR_SI;
      WR_SI:  nxt = WR_SJ;
      WR_SJ:  nxt = RD_F;
      RD_F:   nxt = RD_LAT == 0 ? XOR_WR : W_F;
      W_F:    nxt = cnt_done ? XOR_WR : W_F;
      XOR_WR: nxt = pass ? NEXT : DONE;
      NEXT:   nxt = last ? DONE : INC_I;
      DONE:   nxt = ack ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  // Addresses are held across the wait states so the RAM read latency is absorbed.
  assign s_address = state inside {RD_SI, W_SI, WR_SI} ? i :
                     state inside {RD_SJ, W_SJ, WR_SJ} ? j :
                     state inside {RD_F, W_F, XOR_WR} ? sum : 8'h00;
  assign s_data = state == WR_SI ? sj : state == WR_SJ ? si : 8'h00;
  assign s_write_en = state inside {WR_SI, WR_SJ};
  assign enc_address = k;
  assign dec_address = k;
  assign dec_data = state == XOR_WR ? p : 8'h00;
  assign dec_write_en = state == XOR_WR && pass;
  assign finished = state == DONE;
  assign key_valid = finished && kv;
endmodule

// File: tb/tb_rc4_decrypt.sv
// tb_rc4_decrypt: directed and randomized RC4 decrypt runs checked against a textbook PRGA model.
module tb_rc4_decrypt;
  localparam int ML = 32, AW = 5, RL = 2, CT = 1, BC = 10 + 3 * RL;
  logic clk = 1'b0, reset_n, start, ack;
  logic [7:0] s_address, s_data, s_rd, enc_rd, dec_data;
  logic s_write_en, dec_write_en, finished, key_valid, load = 1'b0;
  logic [AW-1:0] enc_address, dec_address;
  logic [7:0] s_mem[256], s_img[256], m_s[256];
  logic [7:0] enc_mem[ML], enc_img[ML], dec_mem[ML], exp_dec[ML], ks[ML], plain[ML], key[8];
  int checks = 0, failures = 0, exp_nb;
  logic exp_kv;
  rc4_decrypt #(.MSG_LEN(ML), .ADDR_W(AW), .RD_LAT(RL), .CHECK_TEXT(CT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ack(ack),
    .s_address(s_address), .s_data(s_data), .s_write_en(s_write_en), .s_read_data(s_rd),
    .enc_address(enc_address), .enc_read_data(enc_rd),
    .dec_address(dec_address), .dec_data(dec_data), .dec_write_en(dec_write_en),
    .finished(finished), .key_valid(key_valid));
  always #5 clk = ~clk;
  // Synchronous RAMs with one cycle of read latency; load copies the bench images in.
  always @(posedge clk)
    if (load) begin
      s_mem <= s_img;
      enc_mem <= enc_img;
      for (int n = 0; n < ML; n++) dec_mem[n] <= 8'hEE;
    end else begin
      s_rd <= s_mem[s_address];
      enc_rd <= enc_mem[enc_address];
      if (s_write_en) s_mem[s_address] <= s_data;
      if (dec_write_en) dec_mem[dec_address] <= dec_data;
    end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic bit is_text(input logic [7:0] c);
    return (c >= "a" && c <= "z") || c == " ";
  endfunction
  task automatic ksa(input int klen);
    logic [7:0] jj, t;
    for (int x = 0; x < 256; x++) s_img[x] = 8'(x);
    jj = 0;
    for (int x = 0; x < 256; x++) begin
      jj = jj + s_img[x] + key[x % klen];
      t = s_img[x]; s_img[x] = s_img[jj]; s_img[jj] = t;
    end
  endtask
  task automatic model(input bit check);
    logic [7:0] ii, jj, t, idx, p;
    m_s = s_img; exp_kv = 1'b1; exp_nb = ML; ii = 0; jj = 0;
    for (int n = 0; n < ML; n++) exp_dec[n] = 8'hEE;
    for (int n = 0; n < ML; n++) begin
      ii = ii + 1; jj = jj + m_s[ii];
      t = m_s[ii]; m_s[ii] = m_s[jj]; m_s[jj] = t;
      idx = m_s[ii] + m_s[jj];
      ks[n] = m_s[idx];
      p = enc_img[n] ^ ks[n];
      if (check && !is_text(p)) begin exp_kv = 1'b0; exp_nb = n + 1; break; end
      exp_dec[n] = p;
    end
  endtask
  task automatic do_load();
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
  endtask
  task automatic outs_zero(input string tag);
    chk(tag, {s_address, s_data, s_write_en, enc_address, dec_address, dec_data,
              dec_write_en, finished, key_valid}, 64'h0);
  endtask
  task automatic run(input string tag, input bit noise);
    int cyc, bad, expc;
    model(CT == 1);
    expc = exp_kv ? 1 + BC * ML : BC * exp_nb;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (!finished && cyc < 3000) begin
      @(posedge clk); cyc++; #1;
      if (noise) begin start = cyc == 40; ack = cyc == 40; end
    end
    start = 1'b0; ack = 1'b0;
    chk({tag, "_latency"}, 64'(cyc), 64'(expc));
    chk({tag, "_key_valid"}, 64'(key_valid), 64'(exp_kv));
    bad = 0;
    for (int n = 0; n < ML; n++) if (dec_mem[n] !== exp_dec[n]) bad++;
    chk({tag, "_dec_bad_bytes"}, 64'(bad), 64'h0);
    bad = 0;
    for (int n = 0; n < 256; n++) if (s_mem[n] !== m_s[n]) bad++;
    chk({tag, "_s_bad_bytes"}, 64'(bad), 64'h0);
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    chk({tag, "_finished_held"}, 64'(finished), 64'h1);
    chk({tag, "_key_valid_held"}, 64'(key_valid), 64'(exp_kv));
    ack = 1'b1;
    @(posedge clk); #1 ack = 1'b0;
    chk({tag, "_finished_after_ack"}, 64'(finished), 64'h0);
    chk({tag, "_key_valid_after_ack"}, 64'(key_valid), 64'h0);
  endtask
  initial begin
    int bad, c;
    reset_n = 1'b0; start = 1'b0; ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 outs_zero("reset_outputs");
    @(negedge clk) reset_n = 1'b1;
    for (int x = 0; x < 256; x++) s_img[x] = 8'(x);
    for (int n = 0; n < ML; n++) enc_img[n] = 8'h00;
    enc_img[0] = 8'h63; enc_img[1] = 8'h64;
    do_load();
    run("identity", 1'b0);
    chk("id_dec0", 64'(dec_mem[0]), 64'h61);
    chk("id_dec1", 64'(dec_mem[1]), 64'h61);
    chk("id_dec2_stale", 64'(dec_mem[2]), 64'hEE);
    chk("id_i_eq_j_s1", 64'(s_mem[1]), 64'h01);
    chk("id_s2", 64'(s_mem[2]), 64'h03);
    enc_img[0] = 8'h02;
    do_load();
    run("abort_first", 1'b0);
    chk("abort_dec0_stale", 64'(dec_mem[0]), 64'hEE);
    key[0] = 8'h4B; key[1] = 8'h65; key[2] = 8'h79;
    ksa(3);
    for (int n = 0; n < ML; n++) enc_img[n] = 8'h00;
    {enc_img[0], enc_img[1], enc_img[2], enc_img[3], enc_img[4]} = 40'hBBF316E8D9;
    {enc_img[5], enc_img[6], enc_img[7], enc_img[8]} = 32'h40AF0AD3;
    do_load();
    run("key_plaintext", 1'b0);
    for (int t = 0; t < 2; t++) begin
      for (int n = 0; n < 8; n++) key[n] = 8'($urandom);
      ksa(8);
      for (int n = 0; n < ML; n++) begin
        c = $urandom_range(0, 26);
        plain[n] = c == 26 ? 8'h20 : 8'(8'h61 + c);
      end
      plain[0] = "a"; plain[1] = "z"; plain[2] = " ";
      if (t == 1) plain[ML-1] = "{";
      model(1'b0);
      for (int n = 0; n < ML; n++) enc_img[n] = plain[n] ^ ks[n];
      do_load();
      run(t == 0 ? "full_random" : "abort_last", t == 0);
      bad = 0;
      for (int n = 0; n < ML - t; n++) if (dec_mem[n] !== plain[n]) bad++;
      chk("plaintext_recovered", 64'(bad), 64'h0);
    end
    for (int n = 0; n < 8; n++) key[n] = 8'($urandom);
    ksa(8);
    do_load();
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    c = 0;
    while (!s_write_en && c < 100) begin @(posedge clk); c++; #1; end
    chk("reach_wr_si", 64'(s_write_en && s_address == 8'h01), 64'h1);
    reset_n = 1'b0;
    #1 outs_zero("mid_run_reset_outputs");
    @(negedge clk) reset_n = 1'b1;
    bad = 0;
    for (int n = 0; n < 256; n++) if (s_mem[n] !== s_img[n]) bad++;
    chk("reset_s_untouched", 64'(bad), 64'h0);
    do_load();
    run("rerun_after_reset", 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
